// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and constants for the shift-and-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam int MUL_STEPS = 32;
    localparam int CNT_W     = 5;

endpackage
`default_nettype wire

// File: rtl/adder_32bit.sv
`default_nettype none
// ============================================================================
// Module      : adder_32bit
// Description : Combinational 32-bit unsigned adder with carry-out, no carry-in.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] s_o,
    output logic        c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule
`default_nettype wire

// File: rtl/shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mul_ctrl
// Description : Multi-cycle unsigned WIDTHxWIDTH multiplier, one add per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] prod_lo_o,
    output logic [WIDTH-1:0] prod_hi_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(MUL_STEPS - 1);

    mul_state_e       r_state;
    mul_state_e       w_state_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;

    assign w_addend = r_lo[0] ? r_mcand : '0;

    adder_32bit u_adder (
        .a_i (r_acc),
        .b_i (w_addend),
        .s_o (w_sum),
        .c_o (w_carry)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid_i) w_state_next = BUSY;
            BUSY:    if (r_cnt == c_last_step) w_state_next = DONE;
            DONE:    if (out_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (flush_i) begin
            w_state_next = IDLE;
        end
    end

    // Flush only resets control; datapath contents become don't-care.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_mcand <= a_i;
                        r_lo    <= b_i;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    // Carry lands in acc's MSB, so the 2*WIDTH product never overflows.
                    {r_acc, r_lo} <= {w_carry, w_sum, r_lo[WIDTH-1:1]};
                    r_cnt         <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready_o  = (r_state == IDLE);
    assign out_valid_o = (r_state == DONE);
    assign busy_o      = (r_state == BUSY) || (r_state == DONE);
    assign prod_hi_o   = r_acc;
    assign prod_lo_o   = r_lo;

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(out_valid_o && in_ready_o));
            assert (r_cnt <= c_last_step);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mul_ctrl
// Description : Self-checking bench: directed table, corner sequences, random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] prod_lo;
    logic [31:0] prod_hi;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[5];

    shift_add_mul_ctrl #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .prod_lo_o   (prod_lo),
        .prod_hi_o   (prod_hi),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Accept one pair and wait for out_valid; returns edges after the accept edge.
    task automatic start_and_wait(input logic [31:0] av, input logic [31:0] bv, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_handshake_ready", {63'd0, in_ready}, 64'd1);
        check("post_handshake_valid", {63'd0, out_valid}, 64'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat;
        logic [63:0] exp_p;
        logic [63:0] q[$];
        int          accepted;
        int          done_cnt;
        int          cyc;
        logic        got_valid;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h1234_5678,  32'h0,          64'h0};
        vecs[3] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
        vecs[4] = '{32'd7,          32'd6,          64'd42};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_in_ready",  {63'd0, in_ready},  64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_busy",      {63'd0, busy},      64'd0);
        check("reset_prod",      {prod_hi, prod_lo}, 64'd0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 5; i++) begin
            start_and_wait(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
            check($sformatf("vec%0d_product", i), {prod_hi, prod_lo}, vecs[i].exp);
            check($sformatf("vec%0d_busy", i), {63'd0, busy}, 64'd1);
            handshake();
        end

        // Backpressure in DONE, with ignored in_valid
        exp_p = 64'(32'hDEAD_BEEF) * 64'(32'h0BAD_F00D);
        start_and_wait(32'hDEAD_BEEF, 32'h0BAD_F00D, lat);
        check("bp_latency", 64'(lat), 64'd32);
        in_valid = 1'b1; a = 32'd1; b = 32'd1;
        for (int i = 0; i < 10; i++) begin
            check("bp_product", {prod_hi, prod_lo}, exp_p);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        handshake();
        start_and_wait(32'd11, 32'd13, lat);
        check("bp_next_latency", 64'(lat), 64'd32);
        check("bp_next_product", {prod_hi, prod_lo}, 64'd143);
        handshake();

        // Flush at step 10
        @(negedge clk);
        in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_busy",     {63'd0, busy},     64'd0);
        got_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) got_valid = 1'b1;
            @(negedge clk);
        end
        check("flush_no_valid", {63'd0, got_valid}, 64'd0);
        start_and_wait(32'd7, 32'd6, lat);
        check("flush_next_latency", 64'(lat), 64'd32);
        check("flush_next_product", {prod_hi, prod_lo}, 64'd42);
        handshake();

        // Reset at step 20
        @(negedge clk);
        in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_busy",      {63'd0, busy},      64'd0);
        check("midrst_prod",      {prod_hi, prod_lo}, 64'd0);

        // Random traffic against a queue of reference products
        accepted = 0; done_cnt = 0; cyc = 0;
        while (done_cnt < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!in_valid && accepted < 1000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                a = rand_operand();
                b = rand_operand();
            end
            out_ready = $urandom_range(0, 1) != 0;
            if (in_valid && in_ready) begin
                q.push_back(64'(a) * 64'(b));
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_result", {prod_hi, prod_lo}, 64'hX);
                end else begin
                    check("rand_product", {prod_hi, prod_lo}, q.pop_front());
                end
                done_cnt++;
            end
            // Pair is consumed at the coming edge; drop the request afterwards.
            if (in_valid && in_ready) begin
                @(negedge clk);
                cyc++;
                in_valid = 1'b0;
                out_ready = 1'b0;
            end
        end
        check("rand_completed", 64'(done_cnt), 64'd1000);
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
